// File: rtl/regfile_pkg.sv
// Shared types and limits for the indexed register file.
// Used by regfile_idx and idx_cell.
package regfile_pkg;

   typedef enum logic {
      CNT_INC = 1'b0,
      CNT_DEC = 1'b1
   } cnt_dir_t;

   localparam int REGFILE_MAX_DEPTH = 16;
   localparam int REGFILE_MAX_WIDTH = 32;

endpackage

// File: rtl/regfile_idx_cell.sv
// idx_cell: one register with load / increment / decrement.
// o_wrap flags that the requested count rolls over this cycle.
module idx_cell
   import regfile_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic             i_inc,
   input  logic             i_dec,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q,
   output logic             o_wrap
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_d;
      end else if (i_inc) begin
         r_q <= r_q + WIDTH'(1);
      end else if (i_dec) begin
         r_q <= r_q - WIDTH'(1);
      end
   end

   assign o_q    = r_q;
   assign o_wrap = (i_inc && (&r_q)) || (i_dec && ~(|r_q));

endmodule

// File: rtl/regfile_idx.sv
// regfile_idx: register file with per-entry counters and result flags.
// Define REGFILE_IDX_BYPASS_EN for write-through reads.
module regfile_idx
   import regfile_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             cnt_en,
   input  logic [AW-1:0]    cnt_addr,
   input  logic             cnt_dir,
   input  logic [AW-1:0]    raddr_a,
   input  logic [AW-1:0]    raddr_b,
   output logic [WIDTH-1:0] rdata_a,
   output logic [WIDTH-1:0] rdata_b,
   output logic             zero,
   output logic             neg,
   output logic             cnt_wrap
);

   if (DEPTH < 2 || DEPTH > REGFILE_MAX_DEPTH ||
       WIDTH < 2 || WIDTH > REGFILE_MAX_WIDTH) begin : g_bad_cfg
      $error("regfile_idx: unsupported WIDTH/DEPTH");
   end

   logic [WIDTH-1:0] w_q [DEPTH];
   logic [DEPTH-1:0] w_load;
   logic [DEPTH-1:0] w_sel;
   logic [DEPTH-1:0] w_inc;
   logic [DEPTH-1:0] w_dec;
   logic [DEPTH-1:0] w_wrap;
   logic [WIDTH-1:0] w_cnt_cur;
   logic [WIDTH-1:0] w_cnt_res;
   logic [WIDTH-1:0] w_res;
   logic             w_wr_ok;
   logic             w_cnt_ok;
   cnt_dir_t         w_dir;

   logic             r_zero;
   logic             r_neg;
   logic             r_wrap;

   assign w_dir = cnt_dir_t'(cnt_dir);

   // Out-of-range addresses match no cell, so they are silently dropped.
   always_comb begin
      w_load    = '0;
      w_sel     = '0;
      w_cnt_cur = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (waddr == AW'(i)) begin
            w_load[i] = we;
         end
         if (cnt_addr == AW'(i)) begin
            w_sel[i]  = cnt_en;
            w_cnt_cur = w_q[i];
         end
      end
   end

   // A write to the same entry overrides the count.
   assign w_inc    = w_sel & ~w_load & {DEPTH{w_dir == CNT_INC}};
   assign w_dec    = w_sel & ~w_load & {DEPTH{w_dir == CNT_DEC}};
   assign w_wr_ok  = |w_load;
   assign w_cnt_ok = |(w_sel & ~w_load);

   assign w_cnt_res = (w_dir == CNT_DEC) ? w_cnt_cur - WIDTH'(1)
                                         : w_cnt_cur + WIDTH'(1);
   assign w_res     = w_wr_ok ? wdata : w_cnt_res;

   for (genvar g = 0; g < DEPTH; g++) begin : g_cell
      idx_cell #(
         .WIDTH (WIDTH)
      ) u_cell (
         .clk    (clk),
         .reset  (reset),
         .i_load (w_load[g]),
         .i_inc  (w_inc[g]),
         .i_dec  (w_dec[g]),
         .i_d    (wdata),
         .o_q    (w_q[g]),
         .o_wrap (w_wrap[g])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_zero <= 1'b0;
         r_neg  <= 1'b0;
         r_wrap <= 1'b0;
      end else begin
         if (w_wr_ok || w_cnt_ok) begin
            r_zero <= (w_res == '0);
            r_neg  <= w_res[WIDTH-1];
         end
         r_wrap <= |w_wrap;
      end
   end

   assign zero     = r_zero;
   assign neg      = r_neg;
   assign cnt_wrap = r_wrap;

   always_comb begin
      rdata_a = '0;
      rdata_b = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (raddr_a == AW'(i)) begin
            rdata_a = w_q[i];
         end
         if (raddr_b == AW'(i)) begin
            rdata_b = w_q[i];
         end
      end
`ifdef REGFILE_IDX_BYPASS_EN
      if (w_wr_ok && raddr_a == waddr) begin
         rdata_a = wdata;
      end
      if (w_wr_ok && raddr_b == waddr) begin
         rdata_b = wdata;
      end
`endif
   end

endmodule

// File: tb/tb_regfile_idx.sv
// Scoreboard bench for regfile_idx: DEPTH=4 and DEPTH=3 instances
// share one stimulus stream, each checked against its own model.
module tb_regfile_idx;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       we;
   logic [1:0] waddr;
   logic [7:0] wdata;
   logic       cnt_en;
   logic [1:0] cnt_addr;
   logic       cnt_dir;
   logic [1:0] raddr_a;
   logic [1:0] raddr_b;

   logic [7:0] ra4, rb4, ra3, rb3;
   logic       z4, n4, w4, z3, n3, w3;

   regfile_idx #(.WIDTH(8), .DEPTH(4)) u_dut (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr),
      .wdata(wdata), .cnt_en(cnt_en), .cnt_addr(cnt_addr),
      .cnt_dir(cnt_dir), .raddr_a(raddr_a), .raddr_b(raddr_b),
      .rdata_a(ra4), .rdata_b(rb4),
      .zero(z4), .neg(n4), .cnt_wrap(w4)
   );

   regfile_idx #(.WIDTH(8), .DEPTH(3)) u_d3 (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr),
      .wdata(wdata), .cnt_en(cnt_en), .cnt_addr(cnt_addr),
      .cnt_dir(cnt_dir), .raddr_a(raddr_a), .raddr_b(raddr_b),
      .rdata_a(ra3), .rdata_b(rb3),
      .zero(z3), .neg(n3), .cnt_wrap(w3)
   );

`ifdef REGFILE_IDX_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] ra;
      logic [7:0] rb;
      logic       z;
      logic       n;
      logic       w;
   } exp_t;

   exp_t q4[$];
   exp_t q3[$];

   logic [7:0] m [2][4];
   logic       mz [2];
   logic       mn [2];
   logic       mw [2];
   int         dep [2] = '{4, 3};

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [7:0] act,
                      input logic [7:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t",
                    name, act, exp, $time);
   endtask

   function automatic logic [7:0] mrd(input int k, input logic [1:0] a);
      if (int'(a) >= dep[k]) return 8'h00;
      if (BYP && we && a == waddr) return wdata;
      return m[k][a];
   endfunction

   task automatic model_step(input int k);
      logic       wok, cok;
      logic [7:0] old, nv;
      if (reset) begin
         for (int j = 0; j < 4; j++) m[k][j] = 8'h00;
         mz[k] = 1'b0;
         mn[k] = 1'b0;
         mw[k] = 1'b0;
      end else begin
         wok = we && int'(waddr) < dep[k];
         cok = cnt_en && int'(cnt_addr) < dep[k] &&
               !(wok && waddr == cnt_addr);
         old = m[k][cnt_addr];
         nv  = cnt_dir ? old - 8'd1 : old + 8'd1;
         if (wok) m[k][waddr] = wdata;
         if (cok) m[k][cnt_addr] = nv;
         if (wok) begin
            mz[k] = (wdata == 8'h00);
            mn[k] = wdata[7];
         end else if (cok) begin
            mz[k] = (nv == 8'h00);
            mn[k] = nv[7];
         end
         mw[k] = cok && (cnt_dir ? old == 8'h00 : old == 8'hFF);
      end
   endtask

   task automatic cyc(input logic r, input logic w,
                      input logic [1:0] wa, input logic [7:0] wd,
                      input logic ce, input logic [1:0] ca,
                      input logic cd, input logic [1:0] a,
                      input logic [1:0] b);
      exp_t e;
      reset = r; we = w; waddr = wa; wdata = wd;
      cnt_en = ce; cnt_addr = ca; cnt_dir = cd;
      raddr_a = a; raddr_b = b;
      e = '{ra: mrd(0, a), rb: mrd(0, b), z: mz[0], n: mn[0], w: mw[0]};
      q4.push_back(e);
      e = '{ra: mrd(1, a), rb: mrd(1, b), z: mz[1], n: mn[1], w: mw[1]};
      q3.push_back(e);
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic [1:0] a, input logic [1:0] b);
      cyc(0, 0, 0, 8'h00, 0, 0, 0, a, b);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q4.size() > 0) begin
         e = q4.pop_front();
         chk("d4_rdata_a", ra4, e.ra);
         chk("d4_rdata_b", rb4, e.rb);
         chk("d4_zero", {7'd0, z4}, {7'd0, e.z});
         chk("d4_neg", {7'd0, n4}, {7'd0, e.n});
         chk("d4_cnt_wrap", {7'd0, w4}, {7'd0, e.w});
      end
      if (q3.size() > 0) begin
         e = q3.pop_front();
         chk("d3_rdata_a", ra3, e.ra);
         chk("d3_rdata_b", rb3, e.rb);
         chk("d3_zero", {7'd0, z3}, {7'd0, e.z});
         chk("d3_neg", {7'd0, n3}, {7'd0, e.n});
         chk("d3_cnt_wrap", {7'd0, w3}, {7'd0, e.w});
      end
   end

   initial begin
      logic [7:0] wd;
      reset = 1; we = 0; waddr = 0; wdata = 0;
      cnt_en = 0; cnt_addr = 0; cnt_dir = 0;
      raddr_a = 0; raddr_b = 0;
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      cyc(1, 0, 0, 8'h00, 0, 0, 0, 0, 1);
      idle(2, 3);

      cyc(0, 1, 2, 8'h5A, 0, 0, 0, 0, 0);
      idle(2, 2);

      cyc(0, 1, 1, 8'hFF, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 8'h00, 1, 1, 0, 1, 0);
      idle(1, 0);
      idle(1, 0);
      cyc(0, 0, 0, 8'h00, 1, 1, 1, 1, 0);
      idle(1, 0);
      idle(1, 0);

      cyc(0, 1, 3, 8'h10, 1, 3, 0, 3, 0);
      idle(3, 0);
      cyc(0, 1, 0, 8'h80, 1, 3, 0, 0, 3);
      idle(0, 3);

      cyc(0, 1, 1, 8'h33, 0, 0, 0, 1, 1);
      idle(1, 1);

      cyc(1, 1, 2, 8'hAA, 1, 1, 0, 2, 1);
      idle(2, 1);
      idle(0, 3);

      cyc(0, 1, 3, 8'h77, 0, 0, 0, 3, 3);
      idle(3, 3);
      cyc(0, 0, 0, 8'h00, 1, 3, 1, 3, 2);
      idle(3, 2);

      repeat (400) begin
         case ($urandom_range(0, 5))
            0:       wd = 8'h00;
            1:       wd = 8'hFF;
            2:       wd = 8'h80;
            default: wd = 8'($urandom);
         endcase
         cyc($urandom_range(0, 39) == 0, 1'($urandom),
             2'($urandom), wd, 1'($urandom), 2'($urandom),
             1'($urandom), 2'($urandom), 2'($urandom));
      end
      idle(0, 1);

      @(negedge clk);
      #1;
      n_chk++;
      if (q4.size() == 0 && q3.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d/%0d pending expected 0",
                    q4.size(), q3.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
